// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command sequencer: datapath width,
// command encodings, controller states and ALU opcode constants.
package alu_cmd_pkg;

  // Datapath width; must match the 7-bit AND/ADD ALU beside the sequencer.
  localparam int WIDTH = 7;

  // Command opcodes as presented on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_AND   = 2'b01,
    OP_ADD   = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } state_e;

  // ALU opcode values driven on alu_op.
  localparam logic ALU_AND = 1'b0;
  localparam logic ALU_ADD = 1'b1;

  // True for commands that need a round trip through the ALU.
  function automatic logic is_alu_cmd(input logic [1:0] op);
    return (op == OP_AND) || (op == OP_ADD);
  endfunction

  // Maps an ALU command onto the ALU opcode (ADD has bit 1 set).
  function automatic logic alu_op_of(input logic [1:0] op);
    return op[1] ? ALU_ADD : ALU_AND;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Accumulator command sequencer that acts as the initiator of an external
// combinational AND/ADD ALU. Commands arrive on a valid/ready port, ALU
// operands are registered, the result is captured into the accumulator and
// returned on a valid/ready response port.
//
// Build option: define ALU_CTRL_STICKY_CF_EN to make the carry flag sticky
// across AND/ADD commands (cleared only by LOAD, CLEAR or reset).
module alu_cmd_sequencer
  import alu_cmd_pkg::*;
#(
  parameter int WIDTH = alu_cmd_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_gz,
  input  logic             alu_cf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_gz,
  output logic             rsp_cf
);

  state_e state;
  state_e state_nxt;

  logic [WIDTH-1:0] acc;
  logic             gz;
  logic             cf;

  logic accept;
  logic do_load;
  logic do_clear;
  logic do_issue;
  logic do_capture;

  // State register; reset drops any in-flight command back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: ALU commands take ISSUE and CAPTURE, LOAD/CLEAR go straight to RESP.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = is_alu_cmd(cmd_op) ? ISSUE : RESP;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath-enable decode from the current state.
  always_comb begin
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    do_load    = 1'b0;
    do_clear   = 1'b0;
    do_issue   = 1'b0;
    do_capture = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        do_load   = cmd_valid && (cmd_op == OP_LOAD);
        do_clear  = cmd_valid && (cmd_op == OP_CLEAR);
        do_issue  = cmd_valid && is_alu_cmd(cmd_op);
      end
      ISSUE:   ;
      CAPTURE: do_capture = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // ALU operand registers; they hold their last values between commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= ALU_AND;
    end else if (do_issue) begin
      alu_a  <= acc;
      alu_b  <= cmd_data;
      alu_op <= alu_op_of(cmd_op);
    end
  end

  // Accumulator and flags; the ALU result is sampled only in CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      gz  <= 1'b0;
      cf  <= 1'b0;
    end else if (do_load) begin
      acc <= cmd_data;
      gz  <= (cmd_data != '0);
      cf  <= 1'b0;
    end else if (do_clear) begin
      acc <= '0;
      gz  <= 1'b0;
      cf  <= 1'b0;
    end else if (do_capture) begin
      acc <= alu_res;
      gz  <= alu_gz;
`ifdef ALU_CTRL_STICKY_CF_EN
      cf  <= cf | alu_cf;
`else
      cf  <= alu_cf;
`endif
    end
  end

  // The response is the accumulator state, stable for as long as RESP waits.
  always_comb begin
    rsp_res = acc;
    rsp_gz  = gz;
    rsp_cf  = cf;
  end

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer. A combinational 7-bit AND/ADD
// ALU sits beside the DUT; expected responses come from an accumulator
// model written in plain arithmetic. Honours ALU_CTRL_STICKY_CF_EN.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [6:0] cmd_data;
  logic [6:0] alu_a;
  logic [6:0] alu_b;
  logic       alu_op;
  logic [6:0] alu_res;
  logic       alu_gz;
  logic       alu_cf;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [6:0] rsp_res;
  logic       rsp_gz;
  logic       rsp_cf;

  int vectors = 0;
  int miscompares = 0;

  // Reference accumulator state.
  int m_acc = 0;
  bit m_cf  = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(7)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_gz(alu_gz), .alu_cf(alu_cf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_gz(rsp_gz), .rsp_cf(rsp_cf)
  );

  // Behavioural ALU: AND, or ADD modulo 128 with carry out.
  always_comb begin
    int s;
    s = int'(alu_a) + int'(alu_b);
    if (alu_op) begin
      alu_res = 7'(s % 128);
      alu_cf  = (s >= 128);
    end else begin
      alu_res = alu_a & alu_b;
      alu_cf  = 1'b0;
    end
    alu_gz = (alu_res != 7'd0);
  end

  // Accumulator model: applies one command and returns the expected latency.
  task automatic model_apply(input logic [1:0] op, input logic [6:0] d, output int exp_lat);
    int s;
    bit c;
    c = 1'b0;
    exp_lat = 3;
    case (op)
      2'b00: begin m_acc = int'(d); m_cf = 1'b0; exp_lat = 1; end
      2'b11: begin m_acc = 0; m_cf = 1'b0; exp_lat = 1; end
      2'b01: begin m_acc = m_acc & int'(d); c = 1'b0; end
      default: begin
        s = m_acc + int'(d);
        c = (s >= 128);
        m_acc = s % 128;
      end
    endcase
    if (op == 2'b01 || op == 2'b10) begin
`ifdef ALU_CTRL_STICKY_CF_EN
      m_cf = m_cf | c;
`else
      m_cf = c;
`endif
    end
  endtask

  // Drives one command, waits for its response, then completes the handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [6:0] data, input int stall,
                         output logic [6:0] res, output logic gz, output logic cf, output int lat,
                         output logic [6:0] iss_a, output logic [6:0] iss_b, output logic iss_op,
                         output bit timed_out);
    int n;
    timed_out = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) timed_out = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat    = 1;
    iss_a  = alu_a;
    iss_b  = alu_b;
    iss_op = alu_op;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) timed_out = 1'b1;
    repeat (stall) @(negedge clk);
    res = rsp_res;
    gz  = rsp_gz;
    cf  = rsp_cf;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 7'd0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake: got ready/valid %b required 10", {cmd_ready, rsp_valid});
    end
    vectors++;
    if ({alu_a, alu_b, alu_op, rsp_res, rsp_gz, rsp_cf} !== 24'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: got a=%h b=%h op=%b res=%h gz=%b cf=%b required all 0",
               alu_a, alu_b, alu_op, rsp_res, rsp_gz, rsp_cf);
    end
    m_acc = 0;
    m_cf = 1'b0;
  endtask

  task automatic test_load();
    logic [6:0] res, ia, ib;
    logic gz, cf, iop;
    int lat, el;
    bit to;
    model_apply(2'b00, 7'h2A, el);
    run_cmd(2'b00, 7'h2A, 0, res, gz, cf, lat, ia, ib, iop, to);
    vectors++;
    if ({to, res, gz, cf} !== {1'b0, 7'h2A, 1'b1, 1'b0} || lat != 1) begin
      miscompares++;
      $display("[TB] FAIL load_2a: got res=%h gz=%b cf=%b lat=%0d to=%b required res=2a gz=1 cf=0 lat=1",
               res, gz, cf, lat, to);
    end
  endtask

  task automatic test_add_wrap();
    logic [6:0] res, ia, ib;
    logic gz, cf, iop;
    int lat, el;
    bit to;
    model_apply(2'b00, 7'h7F, el);
    run_cmd(2'b00, 7'h7F, 0, res, gz, cf, lat, ia, ib, iop, to);
    model_apply(2'b10, 7'h01, el);
    run_cmd(2'b10, 7'h01, 1, res, gz, cf, lat, ia, ib, iop, to);
    vectors++;
    if ({ia, ib, iop} !== {7'h7F, 7'h01, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL add_issue: got a=%h b=%h op=%b required a=7f b=01 op=1", ia, ib, iop);
    end
    vectors++;
    if ({to, res, gz, cf} !== {1'b0, 7'h00, 1'b0, 1'b1} || lat != 3) begin
      miscompares++;
      $display("[TB] FAIL add_wrap: got res=%h gz=%b cf=%b lat=%0d to=%b required res=00 gz=0 cf=1 lat=3",
               res, gz, cf, lat, to);
    end
  endtask

  task automatic test_and();
    logic [6:0] res, ia, ib;
    logic gz, cf, iop;
    int lat, el;
    bit to;
    model_apply(2'b00, 7'h5A, el);
    run_cmd(2'b00, 7'h5A, 0, res, gz, cf, lat, ia, ib, iop, to);
    model_apply(2'b01, 7'h0F, el);
    run_cmd(2'b01, 7'h0F, 0, res, gz, cf, lat, ia, ib, iop, to);
    vectors++;
    if (iop !== 1'b0 || {to, res, gz, cf} !== {1'b0, 7'h0A, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL and_mask: got op=%b res=%h gz=%b cf=%b to=%b required op=0 res=0a gz=1 cf=0",
               iop, res, gz, cf, to);
    end
  endtask

  task automatic test_backpressure();
    bit held_ok;
    held_ok = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 7'h15;
    @(posedge clk);
    #1 cmd_data = 7'h6C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_res !== 7'h15 || cmd_ready !== 1'b0) held_ok = 1'b0;
    end
    vectors++;
    if (!held_ok) begin
      miscompares++;
      $display("[TB] FAIL stall_hold: got valid=%b res=%h ready=%b required valid=1 res=15 ready=0 for 5 cycles",
               rsp_valid, rsp_res, cmd_ready);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got ready/valid %b required 10", {cmd_ready, rsp_valid});
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_res !== 7'h6C) begin
      miscompares++;
      $display("[TB] FAIL stall_pending: got valid=%b res=%h required valid=1 res=6c", rsp_valid, rsp_res);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    m_acc = 'h6C;
    m_cf = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    logic [6:0] res, ia, ib;
    logic gz, cf, iop;
    int lat, el;
    bit to, saw_rsp;
    model_apply(2'b00, 7'h33, el);
    run_cmd(2'b00, 7'h33, 0, res, gz, cf, lat, ia, ib, iop, to);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_data  = 7'h11;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_op, rsp_res, rsp_gz, rsp_cf} !== {2'b10, 24'd0}) begin
      miscompares++;
      $display("[TB] FAIL rst_issue: got ready=%b valid=%b a=%h b=%h op=%b res=%h gz=%b cf=%b required ready=1 rest 0",
               cmd_ready, rsp_valid, alu_a, alu_b, alu_op, rsp_res, rsp_gz, rsp_cf);
    end
    saw_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    vectors++;
    if (saw_rsp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_drop: got a response for dropped ADD, required none");
    end
    m_acc = 0;
    m_cf = 1'b0;
  endtask

  task automatic test_sticky_cf();
    logic [6:0] res, ia, ib;
    logic gz, cf, iop;
    int lat, el;
    bit to;
    logic exp_cf;
`ifdef ALU_CTRL_STICKY_CF_EN
    exp_cf = 1'b1;
`else
    exp_cf = 1'b0;
`endif
    model_apply(2'b00, 7'h7F, el);
    run_cmd(2'b00, 7'h7F, 0, res, gz, cf, lat, ia, ib, iop, to);
    model_apply(2'b10, 7'h01, el);
    run_cmd(2'b10, 7'h01, 0, res, gz, cf, lat, ia, ib, iop, to);
    model_apply(2'b01, 7'h00, el);
    run_cmd(2'b01, 7'h00, 0, res, gz, cf, lat, ia, ib, iop, to);
    vectors++;
    if (cf !== exp_cf || res !== 7'h00 || to) begin
      miscompares++;
      $display("[TB] FAIL sticky_and: got cf=%b res=%h to=%b required cf=%b res=00", cf, res, to, exp_cf);
    end
    model_apply(2'b11, 7'h55, el);
    run_cmd(2'b11, 7'h55, 0, res, gz, cf, lat, ia, ib, iop, to);
    vectors++;
    if ({to, res, gz, cf} !== {1'b0, 7'h00, 1'b0, 1'b0} || lat != 1) begin
      miscompares++;
      $display("[TB] FAIL clear_cf: got res=%h gz=%b cf=%b lat=%0d required res=00 gz=0 cf=0 lat=1",
               res, gz, cf, lat);
    end
  endtask

  task automatic test_random();
    logic [6:0] res, ia, ib, d, exp_res;
    logic gz, cf, iop;
    logic [1:0] op;
    int lat, el;
    bit to;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = 7'($urandom);
      model_apply(op, d, el);
      exp_res = 7'(m_acc);
      run_cmd(op, d, int'($urandom_range(0, 2)), res, gz, cf, lat, ia, ib, iop, to);
      vectors++;
      if ({to, res, gz, cf} !== {1'b0, exp_res, (exp_res != 7'd0), m_cf} || lat != el) begin
        miscompares++;
        $display("[TB] FAIL random_%0d op=%0d d=%h: got res=%h gz=%b cf=%b lat=%0d to=%b required res=%h gz=%b cf=%b lat=%0d",
                 i, op, d, res, gz, cf, lat, to, exp_res, (exp_res != 7'd0), m_cf, el);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_add_wrap();
    test_and();
    test_backpressure();
    test_reset_in_flight();
    test_sticky_cf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
